// File: rtl/router_fsm_nch.sv
// Packet-control FSM for a 1xN router: decodes the header address and sequences
// header/payload/parity writes into one of N output FIFOs, with wait timeout and drop.
module router_fsm_nch #(
    parameter int unsigned NUM_PORTS    = 3,
    parameter int unsigned ADDR_WIDTH   = 2,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned WAIT_TIMEOUT = 30
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pkt_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  parity_done,
    input  logic                  low_pkt_valid,
    input  logic [NUM_PORTS-1:0]  fifo_full,
    input  logic [NUM_PORTS-1:0]  fifo_empty,
    input  logic [NUM_PORTS-1:0]  soft_reset,
    output logic                  busy,
    output logic                  detect_add,
    output logic                  lfd_state,
    output logic                  ld_state,
    output logic                  laf_state,
    output logic                  full_state,
    output logic                  rst_int_reg,
    output logic                  write_enb_reg,
    output logic [NUM_PORTS-1:0]  write_enb,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic                  drop_state,
    output logic                  timeout_err
);

    localparam int unsigned NSLOT = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W = (WAIT_TIMEOUT > 2) ? $clog2(WAIT_TIMEOUT) : 1;

    typedef enum logic [3:0] {
        ST_DECODE       = 4'd0,
        ST_LFD          = 4'd1,
        ST_WAIT_EMPTY   = 4'd2,
        ST_LOAD_DATA    = 4'd3,
        ST_FIFO_FULL    = 4'd4,
        ST_LAF          = 4'd5,
        ST_LOAD_PARITY  = 4'd6,
        ST_CHECK_PARITY = 4'd7,
        ST_DROP         = 4'd8,
        ST_DROP_PARITY  = 4'd9
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [ADDR_WIDTH-1:0]   hdr_addr;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    timeout_d;
    logic [NSLOT-1:0]        empty_ext, full_ext, srst_ext;
    logic                    data_unused;

    // Only the address bits of the header matter to the controller.
    assign data_unused = ^data_in;

    // Next-state, address latch and wait counter.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_out;
        cnt_d     = '0;
        timeout_d = 1'b0;
        hdr_addr  = data_in[ADDR_WIDTH-1:0];
        empty_ext = NSLOT'(fifo_empty);
        full_ext  = NSLOT'(fifo_full);
        srst_ext  = NSLOT'(soft_reset);

        case (state_q)
            ST_DECODE: begin
                if (pkt_valid) begin
                    addr_d = hdr_addr;
                    if (32'(hdr_addr) >= NUM_PORTS) begin
                        state_d = ST_DROP;
                    end else if (empty_ext[hdr_addr]) begin
                        state_d = ST_LFD;
                    end else begin
                        state_d = ST_WAIT_EMPTY;
                    end
                end
            end
            ST_LFD: state_d = ST_LOAD_DATA;
            ST_WAIT_EMPTY: begin
                if (empty_ext[addr_out]) begin
                    state_d = ST_LFD;
                end else if (cnt_q == CNT_W'(WAIT_TIMEOUT - 1)) begin
                    state_d   = ST_DROP;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LOAD_DATA: begin
                if (full_ext[addr_out]) begin
                    state_d = ST_FIFO_FULL;
                end else if (!pkt_valid) begin
                    state_d = ST_LOAD_PARITY;
                end
            end
            ST_FIFO_FULL: begin
                if (!full_ext[addr_out]) begin
                    state_d = ST_LAF;
                end
            end
            ST_LAF: begin
                if (parity_done) begin
                    state_d = ST_DECODE;
                end else if (low_pkt_valid) begin
                    state_d = ST_LOAD_PARITY;
                end else begin
                    state_d = ST_LOAD_DATA;
                end
            end
            ST_LOAD_PARITY:  state_d = ST_CHECK_PARITY;
            ST_CHECK_PARITY: state_d = full_ext[addr_out] ? ST_FIFO_FULL : ST_DECODE;
            ST_DROP:         state_d = pkt_valid ? ST_DROP : ST_DROP_PARITY;
            ST_DROP_PARITY:  state_d = ST_DECODE;
            default:         state_d = ST_DECODE;
        endcase

        // Soft reset of the latched channel aborts any packet in flight.
        if (srst_ext[addr_out] &&
            !(state_q inside {ST_DECODE, ST_DROP, ST_DROP_PARITY})) begin
            state_d   = ST_DECODE;
            cnt_d     = '0;
            timeout_d = 1'b0;
        end
    end

    // State register with outputs decoded from the next state so they align with it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_DECODE;
            addr_out      <= '0;
            cnt_q         <= '0;
            timeout_err   <= 1'b0;
            busy          <= 1'b0;
            detect_add    <= 1'b1;
            lfd_state     <= 1'b0;
            ld_state      <= 1'b0;
            laf_state     <= 1'b0;
            full_state    <= 1'b0;
            rst_int_reg   <= 1'b0;
            write_enb_reg <= 1'b0;
            drop_state    <= 1'b0;
            write_enb     <= '0;
        end else begin
            state_q       <= state_d;
            addr_out      <= addr_d;
            cnt_q         <= cnt_d;
            timeout_err   <= timeout_d;
            busy          <= state_d inside {ST_LFD, ST_WAIT_EMPTY, ST_FIFO_FULL,
                                             ST_LAF, ST_LOAD_PARITY, ST_CHECK_PARITY};
            detect_add    <= (state_d == ST_DECODE);
            lfd_state     <= (state_d == ST_LFD);
            ld_state      <= (state_d == ST_LOAD_DATA);
            laf_state     <= (state_d == ST_LAF);
            full_state    <= (state_d == ST_FIFO_FULL);
            rst_int_reg   <= (state_d == ST_CHECK_PARITY);
            write_enb_reg <= state_d inside {ST_LOAD_DATA, ST_LAF, ST_LOAD_PARITY};
            drop_state    <= state_d inside {ST_DROP, ST_DROP_PARITY};
            if (state_d inside {ST_LFD, ST_LOAD_DATA, ST_LAF, ST_LOAD_PARITY}) begin
                write_enb <= NUM_PORTS'(NSLOT'(1) << addr_d);
            end else begin
                write_enb <= '0;
            end
        end
    end

endmodule

// File: tb/tb_router_fsm_nch.sv
// Directed and randomized checks of router_fsm_nch against a packet-level model.
module tb_router_fsm_nch;

    localparam int unsigned NP = 3;
    localparam int unsigned AW = 2;
    localparam int unsigned DW = 8;
    localparam int unsigned TO = 30;

    typedef enum int {P_DEC, P_LFD, P_WAIT, P_LD, P_FULL, P_LAF, P_LP, P_CP, P_DROP, P_DP} phase_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          pkt_valid;
    logic [DW-1:0] data_in;
    logic          parity_done;
    logic          low_pkt_valid;
    logic [NP-1:0] fifo_full, fifo_empty, soft_reset;
    logic          busy, detect_add, lfd_state, ld_state, laf_state, full_state;
    logic          rst_int_reg, write_enb_reg, drop_state, timeout_err;
    logic [NP-1:0] write_enb;
    logic [AW-1:0] addr_out;

    int checks = 0;
    int errors = 0;

    router_fsm_nch #(
        .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_TIMEOUT(TO)
    ) dut (
        .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
        .busy(busy), .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
        .write_enb_reg(write_enb_reg), .write_enb(write_enb), .addr_out(addr_out),
        .drop_state(drop_state), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Output flags {busy, detect_add, lfd, ld, laf, full, rst_int_reg, write_enb_reg, drop}.
    function automatic logic [8:0] exp_flags(input phase_t ph);
        case (ph)
            P_DEC:   return 9'b0_1_0_0_0_0_0_0_0;
            P_LFD:   return 9'b1_0_1_0_0_0_0_0_0;
            P_WAIT:  return 9'b1_0_0_0_0_0_0_0_0;
            P_LD:    return 9'b0_0_0_1_0_0_0_1_0;
            P_FULL:  return 9'b1_0_0_0_0_1_0_0_0;
            P_LAF:   return 9'b1_0_0_0_1_0_0_1_0;
            P_LP:    return 9'b1_0_0_0_0_0_0_1_0;
            P_CP:    return 9'b1_0_0_0_0_0_1_0_0;
            default: return 9'b0_0_0_0_0_0_0_0_1;
        endcase
    endfunction

    function automatic logic [NP-1:0] exp_we(input phase_t ph, input int a);
        logic [NP-1:0] one;
        one = NP'(1);
        if (ph inside {P_LFD, P_LD, P_LAF, P_LP}) return one << a;
        return '0;
    endfunction

    task automatic chk(input string tag, input phase_t ph, input int a, input logic to);
        logic [8:0]    obs, expf;
        logic [NP-1:0] expw;
        logic [AW-1:0] expa;
        obs  = {busy, detect_add, lfd_state, ld_state, laf_state, full_state,
                rst_int_reg, write_enb_reg, drop_state};
        expf = exp_flags(ph);
        expw = exp_we(ph, a);
        expa = AW'(a);
        checks++;
        assert (obs === expf) else begin
            errors++;
            $error("FAIL %s flags (%s): got %b expected %b", tag, ph.name(), obs, expf);
        end
        checks++;
        assert (write_enb === expw) else begin
            errors++;
            $error("FAIL %s write_enb (%s): got %b expected %b", tag, ph.name(), write_enb, expw);
        end
        checks++;
        assert (addr_out === expa) else begin
            errors++;
            $error("FAIL %s addr_out: got %0d expected %0d", tag, addr_out, expa);
        end
        checks++;
        assert (timeout_err === to) else begin
            errors++;
            $error("FAIL %s timeout_err (%s): got %b expected %b", tag, ph.name(), timeout_err, to);
        end
    endtask

    task automatic set_in(input logic pv, input logic [DW-1:0] d, input logic [NP-1:0] emp,
                          input logic [NP-1:0] ful, input logic [NP-1:0] sr,
                          input logic pd, input logic lpv);
        pkt_valid     = pv;
        data_in       = d;
        fifo_empty    = emp;
        fifo_full     = ful;
        soft_reset    = sr;
        parity_done   = pd;
        low_pkt_valid = lpv;
    endtask

    task automatic step(input string tag, input phase_t ph, input int a);
        @(posedge clock);
        #1;
        chk(tag, ph, a, 1'b0);
    endtask

    // Packet-level model: wait min(w,TO) cycles, drop on timeout or bad address.
    task automatic run_packet(input string tag, input int a, input int n, input int w);
        phase_t        q[$];
        int            to_idx, k, sample;
        phase_t        cur;
        logic [NP-1:0] mask;
        logic [DW-1:0] hdr;
        to_idx = -1;
        if (a >= int'(NP)) begin
            repeat (n) q.push_back(P_DROP);
            q.push_back(P_DP);
        end else if (w > int'(TO)) begin
            repeat (TO) q.push_back(P_WAIT);
            to_idx = int'(TO);
            repeat (n) q.push_back(P_DROP);
            q.push_back(P_DP);
        end else begin
            repeat (w) q.push_back(P_WAIT);
            q.push_back(P_LFD);
            repeat (n) q.push_back(P_LD);
            q.push_back(P_LP);
            q.push_back(P_CP);
        end
        q.push_back(P_DEC);

        mask = NP'(1) << a;
        hdr  = DW'($urandom);
        hdr[AW-1:0] = AW'(a);
        cur = P_DEC;
        k = 1;
        sample = 0;
        for (int idx = 0; idx < q.size(); idx++) begin
            case (cur)
                P_DEC:         pkt_valid = 1'b1;
                P_WAIT, P_LFD: pkt_valid = 1'b1;
                P_LD, P_DROP:  pkt_valid = (k < n);
                default:       pkt_valid = 1'b0;
            endcase
            data_in       = (cur == P_DEC) ? hdr : DW'($urandom);
            fifo_empty    = (NP'($urandom) & ~mask) | ((sample >= w) ? mask : '0);
            fifo_full     = NP'($urandom) & ~mask;
            soft_reset    = NP'($urandom) & ~mask;
            parity_done   = 1'($urandom);
            low_pkt_valid = 1'($urandom);
            @(posedge clock);
            #1;
            chk(tag, q[idx], a, (idx == to_idx));
            if (q[idx] == cur) k++;
            else begin
                cur = q[idx];
                k = 1;
            end
            sample++;
        end
    endtask

    initial begin
        reset = 1'b1;
        set_in(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        chk("reset", P_DEC, 0, 1'b0);
        reset = 1'b0;
        step("idle", P_DEC, 0);

        run_packet("basic_a1", 1, 4, 0);
        run_packet("drop_a3", 3, 3, 0);
        run_packet("timeout_a2", 2, 2, 40);
        run_packet("late_empty_a2", 2, 2, 30);

        // Back-pressure, then low_pkt_valid out of LAF.
        set_in(1'b1, 8'h00, 3'b111, 3'b000, 3'b000, 1'b0, 1'b0); step("full1", P_LFD, 0);
        set_in(1'b1, 8'h11, 3'b111, 3'b000, 3'b000, 1'b0, 1'b0); step("full1", P_LD, 0);
        set_in(1'b1, 8'h22, 3'b111, 3'b001, 3'b000, 1'b0, 1'b0); step("full1", P_FULL, 0);
        set_in(1'b1, 8'h22, 3'b111, 3'b001, 3'b000, 1'b0, 1'b0); step("full1", P_FULL, 0);
        set_in(1'b0, 8'h22, 3'b111, 3'b000, 3'b000, 1'b0, 1'b0); step("full1", P_LAF, 0);
        set_in(1'b0, 8'h33, 3'b111, 3'b000, 3'b000, 1'b0, 1'b1); step("full1", P_LP, 0);
        set_in(1'b0, 8'h44, 3'b111, 3'b000, 3'b000, 1'b0, 1'b0); step("full1", P_CP, 0);
        step("full1", P_DEC, 0);

        // parity_done out of LAF.
        set_in(1'b1, 8'h00, 3'b111, 3'b000, 3'b000, 1'b0, 1'b0); step("full2", P_LFD, 0);
        set_in(1'b1, 8'h11, 3'b111, 3'b000, 3'b000, 1'b0, 1'b0); step("full2", P_LD, 0);
        set_in(1'b1, 8'h22, 3'b111, 3'b001, 3'b000, 1'b0, 1'b0); step("full2", P_FULL, 0);
        set_in(1'b1, 8'h22, 3'b111, 3'b000, 3'b000, 1'b0, 1'b0); step("full2", P_LAF, 0);
        set_in(1'b0, 8'h22, 3'b111, 3'b000, 3'b000, 1'b1, 1'b1); step("full2", P_DEC, 0);

        // Soft reset wins over LAF in FIFO_FULL.
        set_in(1'b1, 8'h00, 3'b111, 3'b000, 3'b000, 1'b0, 1'b0); step("srfull", P_LFD, 0);
        set_in(1'b1, 8'h11, 3'b111, 3'b000, 3'b000, 1'b0, 1'b0); step("srfull", P_LD, 0);
        set_in(1'b1, 8'h22, 3'b111, 3'b001, 3'b000, 1'b0, 1'b0); step("srfull", P_FULL, 0);
        set_in(1'b1, 8'h22, 3'b111, 3'b000, 3'b001, 1'b0, 1'b0); step("srfull", P_DEC, 0);

        // CHECK_PARITY back into FIFO_FULL, then soft reset of channel 1.
        set_in(1'b1, 8'h01, 3'b111, 3'b000, 3'b000, 1'b0, 1'b0); step("cpfull", P_LFD, 1);
        set_in(1'b0, 8'h11, 3'b111, 3'b000, 3'b000, 1'b0, 1'b0); step("cpfull", P_LD, 1);
        set_in(1'b0, 8'h11, 3'b111, 3'b000, 3'b000, 1'b0, 1'b0); step("cpfull", P_LP, 1);
        set_in(1'b0, 8'h11, 3'b111, 3'b010, 3'b000, 1'b0, 1'b0); step("cpfull", P_CP, 1);
        step("cpfull", P_FULL, 1);
        set_in(1'b0, 8'h11, 3'b111, 3'b010, 3'b010, 1'b0, 1'b0); step("cpfull", P_DEC, 1);

        // soft_reset of another channel is ignored; of the latched one aborts.
        set_in(1'b1, 8'hA2, 3'b111, 3'b000, 3'b000, 1'b0, 1'b0); step("srload", P_LFD, 2);
        set_in(1'b1, 8'h11, 3'b111, 3'b000, 3'b000, 1'b0, 1'b0); step("srload", P_LD, 2);
        set_in(1'b1, 8'h11, 3'b111, 3'b000, 3'b001, 1'b0, 1'b0); step("sr_other", P_LD, 2);
        set_in(1'b1, 8'h11, 3'b111, 3'b000, 3'b100, 1'b0, 1'b0); step("sr_own", P_DEC, 2);
        set_in(1'b0, 8'h00, 3'b111, 3'b000, 3'b000, 1'b0, 1'b0); step("idle2", P_DEC, 2);

        // Reset in FIFO_FULL.
        set_in(1'b1, 8'h00, 3'b111, 3'b000, 3'b000, 1'b0, 1'b0); step("rstfull", P_LFD, 0);
        set_in(1'b1, 8'h11, 3'b111, 3'b000, 3'b000, 1'b0, 1'b0); step("rstfull", P_LD, 0);
        set_in(1'b1, 8'h22, 3'b111, 3'b001, 3'b000, 1'b0, 1'b0); step("rstfull", P_FULL, 0);
        reset = 1'b1;
        step("rstfull", P_DEC, 0);
        reset = 1'b0;
        set_in(1'b0, 8'h00, 3'b111, 3'b000, 3'b000, 1'b0, 1'b0); step("idle3", P_DEC, 0);

        // Randomized packets.
        for (int p = 0; p < 40; p++) begin
            int a, n, w;
            a = int'($urandom_range(0, 3));
            n = int'($urandom_range(1, 5));
            w = ($urandom_range(0, 3) == 0) ? int'($urandom_range(28, 35))
                                            : int'($urandom_range(0, 4));
            run_packet("rand", a, n, w);
            set_in(1'b0, DW'($urandom), NP'($urandom), NP'($urandom), NP'($urandom),
                   1'b0, 1'b0);
            step("rand_idle", P_DEC, a);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
